// File: rtl/sync_queue_param.sv
// rtl/sync_queue_param.sv - parametrised first-word-fall-through synchronous FIFO
// Optional peak-occupancy monitor (hwm port) built when SYNC_QUEUE_HWM_EN is defined.
module sync_queue_param #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [WIDTH-1:0]         enq_bits,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [WIDTH-1:0]         deq_bits,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty,
`ifdef SYNC_QUEUE_HWM_EN
    output logic [$clog2(DEPTH):0]   hwm,
`endif
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [AW-1:0]    enq_ptr;
    logic [AW-1:0]    deq_ptr;
    logic [AW-1:0]    rd_addr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             do_enq;
    logic             do_deq;
    logic             ovf_q;

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match && !maybe_full;
    assign full      = ptr_match && maybe_full;
    assign enq_ready = !full;
    assign deq_valid = !empty;
    // Flush wins over traffic: nothing is written or popped in a flush cycle.
    assign do_enq    = enq_valid && enq_ready && !flush;
    assign do_deq    = deq_ready && deq_valid && !flush;

    // Prefetch the next head so deq_bits is valid the cycle after a pop.
    assign rd_addr   = do_deq ? deq_ptr + AW'(1) : deq_ptr;

    always_ff @(posedge clock) begin
        if (do_enq) begin
            mem[enq_ptr] <= enq_bits;
        end
    end

    // Bypass covers an enq landing on the slot that becomes the head.
    always_ff @(posedge clock) begin
        if (do_enq && (enq_ptr == rd_addr)) begin
            head_q <= enq_bits;
        end else begin
            head_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (do_enq) begin
                enq_ptr <= enq_ptr + AW'(1);
            end
            if (do_deq) begin
                deq_ptr <= deq_ptr + AW'(1);
            end
            if (do_enq != do_deq) begin
                maybe_full <= do_enq;
            end
            if (enq_valid && !enq_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign deq_bits     = head_q;
    assign count        = {full, enq_ptr - deq_ptr};
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign overflow     = ovf_q;

`ifdef SYNC_QUEUE_HWM_EN
    // Survives flush so the peak spans frames.
    always_ff @(posedge clock) begin
        if (reset) begin
            hwm <= '0;
        end else if (count > hwm) begin
            hwm <= count;
        end
    end
`endif
endmodule

// File: doc/sync_queue_param.md
Name: sync_queue_param

Overview:
Parametrised first-word-fall-through synchronous FIFO. It is the generalised successor to the fixed 32x64 flushable queue used in the cave memory and graphics paths. Width, depth and watermark levels are parameters. Adds enq_ready back-pressure, almost_full/almost_empty flags, a sticky overflow flag and an optional high-water-mark monitor.

Parameters:
WIDTH, 64, data width in bits (>=1)
DEPTH, 32, entry count; power of two, >=2
AF_LEVEL, DEPTH-4, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL

Ports:
clock  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
flush  in  1  synchronous clear of contents (pointers/flags), no data wipe
enq_valid  in  1  producer has data
enq_ready  out  1  queue can accept (= not full)
enq_bits  in  WIDTH  write data
deq_ready  in  1  consumer takes head
deq_valid  out  1  head valid (= not empty)
deq_bits  out  WIDTH  head data, valid when deq_valid
count  out  log2(DEPTH)+1  occupancy 0..DEPTH
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
overflow  out  1  sticky: enq_valid seen while enq_ready=0
hwm  out  log2(DEPTH)+1  peak count (only with SYNC_QUEUE_HWM_EN)

Behaviour:
- Storage: DEPTH x WIDTH sync-read RAM. Pointers enq_ptr/deq_ptr are log2(DEPTH) bits, wrapping naturally. maybe_full bit disambiguates ptr equality.
- empty = ptrs equal & !maybe_full; full = ptrs equal & maybe_full.
- do_enq = enq_valid & enq_ready; do_deq = deq_ready & deq_valid.
- No pass-through: enq when full is rejected even if a deq occurs in the same cycle. deq when empty does nothing.
- maybe_full next: unchanged if do_enq==do_deq, else = do_enq.
- FWFT: RAM read address = deq_ptr+1 when do_deq, else deq_ptr. deq_bits always reflects the current head.
- Read-during-write to the same address returns the new data; a bypass register is required. An enq into an empty queue gives deq_valid=1 with correct deq_bits on the next cycle (latency 1).
- count = {full, enq_ptr - deq_ptr} (modular subtraction); flags are combinational from count.
- flush: next cycle pointers=0, maybe_full=0, overflow=0. Flush overrides enq/deq in the same cycle; enq data in the flush cycle is discarded. enq_ready stays driven from current state during flush.
- overflow: set on enq_valid & !enq_ready; cleared only by reset/flush.
- Reset values: deq_valid=0, enq_ready=1, count=0, almost_full=(AF_LEVEL==0), almost_empty=1, overflow=0, hwm=0. deq_bits is don't-care.
- Reset mid-traffic discards all contents, identical to flush.

Optional Feature:
SYNC_QUEUE_HWM_EN defined:
- hwm register updates to count when count > hwm.
- Cleared by reset only, not by flush, so peak occupancy is retained across frames.

SYNC_QUEUE_HWM_EN undefined:
- hwm port is absent and no register is built.

Test Plan:
- Reset, DEPTH=32: enq 1 word 0xA5 -> deq_valid=1 next cycle, deq_bits=0xA5, count=1, almost_empty=1.
- Enq 32 words without deq -> count=32, enq_ready=0, almost_full=1 from count 28. A 33rd enq_valid sets overflow=1 and count stays 32.
- Full queue, enq_valid & deq_ready same cycle -> deq occurs, enq rejected, count=31, overflow=1.
- Continuous enq+deq for 100 cycles with incrementing data -> in-order output, count constant, pointers wrap cleanly past 31->0.
- Fill 10, assert flush with enq_valid=1 -> next cycle count=0, deq_valid=0, overflow=0. The flush-cycle enq data never appears.
- HWM_EN: fill 20, drain to 0, flush -> hwm=20. Fill 25 -> hwm=25. Reset -> hwm=0.
